// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the mem_bridge memory front end.
// The MEM_BRIDGE_BYTE_EN build option is handled in mem_bridge.sv.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WAIT_CNT_W = 4;

  // Misaligned, or word index outside [0, depth); below-base addresses wrap huge.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || ({2'b00, off[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_bridge_ram.sv
// Single-port synchronous RAM, byte-lane write enables, old data on read-during-write.
module mem_bridge_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter     INIT_FILE   = "",
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  input  logic [3:0]       we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset branch; clearing a memory array on reset
  // forbids RAM-macro inference, and its contents must survive reset anyway.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bridge.sv
// Wait-state memory bridge: FSM, request latches, range check and error reporting.
// Optional build macro: MEM_BRIDGE_BYTE_EN adds cpu_be and byte-lane writes.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        cpu_valid,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
`ifdef MEM_BRIDGE_BYTE_EN
  input  logic [3:0]  cpu_be,
`endif
  output logic        mem_rdy,
  output logic [31:0] cpu_rdata,
  output logic        mem_err,
  output logic        err_sticky,
  output logic        busy
);

  localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [31:0]           addr_q, wdata_q, rdata_hold, ram_rdata;
  logic [31:0]           sel_addr, sel_off;
  logic                  we_q, acc_err, req_err;
  logic [3:0]            be_q, req_be, ram_we;
  logic [IDX_W-1:0]      ram_idx;

`ifdef MEM_BRIDGE_BYTE_EN
  assign req_be = cpu_be;
`else
  assign req_be = 4'hF;
`endif

  assign acc_err = addr_err(addr_q, BASE_ADDR, 32'(DEPTH_WORDS));
  assign req_err = addr_err(cpu_addr, BASE_ADDR, 32'(DEPTH_WORDS));

  // The read is issued from the live address in IDLE (zero-wait case) and from
  // the latched one in the final WAIT cycle, so the RAM output lines up with DONE.
  always_comb begin
    sel_addr = (state == IDLE) ? cpu_addr : addr_q;
    sel_off  = sel_addr - BASE_ADDR;
    ram_idx  = sel_off[IDX_W+1:2];
    ram_we   = (state == DONE && we_q && !acc_err && !sys_rst) ? be_q : 4'b0000;
  end

  mem_bridge_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .addr (ram_idx),
    .we   (ram_we),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    cpu_rdata = rdata_hold;
    if (state == DONE) begin
      if (acc_err)    cpu_rdata = '0;
      else if (!we_q) cpu_rdata = ram_rdata;
    end
  end

  // NOTE: the request latches are left out of reset on purpose; they are only
  // consumed after IDLE has loaded them, so a reset term would be dead logic.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      mem_rdy    <= 1'b0;
      mem_err    <= 1'b0;
      err_sticky <= 1'b0;
      busy       <= 1'b0;
      rdata_hold <= '0;
    end else begin
      mem_rdy <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_valid || cpu_we) begin
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            we_q     <= cpu_we;
            be_q     <= req_be;
            wait_cnt <= WAIT_LOAD;
            busy     <= 1'b1;
            if (WAIT_LOAD == '0) begin
              state      <= DONE;
              mem_rdy    <= 1'b1;
              mem_err    <= req_err;
              err_sticky <= err_sticky | req_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == WAIT_CNT_W'(1)) begin
            state      <= DONE;
            mem_rdy    <= 1'b1;
            mem_err    <= acc_err;
            err_sticky <= err_sticky | acc_err;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (acc_err)    rdata_hold <= '0;
          else if (!we_q) rdata_hold <= ram_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Randomized self-checking bench for mem_bridge against a word-array reference model.
// Exercises byte-lane writes as well when MEM_BRIDGE_BYTE_EN is defined.
module tb_mem_bridge;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WAITS = 2;
  localparam int          DEPTH0 = 16;
  localparam logic [31:0] BASE0  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        cpu_valid, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        mem_rdy, mem_err, err_sticky, busy;
  logic [31:0] cpu_rdata;
  logic        valid0, we0;
  logic [31:0] addr0, wdata0;
  logic        rdy0, err0, sticky0, busy0;
  logic [31:0] rdata0;
`ifdef MEM_BRIDGE_BYTE_EN
  logic [3:0]  cpu_be;
  logic [3:0]  be0;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] hold_m;
  logic        sticky_m;
  logic [31:0] w0, w1;

  always #5 clk = ~clk;

  mem_bridge #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITS), .INIT_FILE("")) u_dut (
    .clk(clk), .sys_rst(sys_rst), .cpu_valid(cpu_valid), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef MEM_BRIDGE_BYTE_EN
    .cpu_be(cpu_be),
`endif
    .mem_rdy(mem_rdy), .cpu_rdata(cpu_rdata), .mem_err(mem_err),
    .err_sticky(err_sticky), .busy(busy)
  );

  mem_bridge #(.DEPTH_WORDS(DEPTH0), .BASE_ADDR(BASE0), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .sys_rst(sys_rst), .cpu_valid(valid0), .cpu_we(we0),
    .cpu_addr(addr0), .cpu_wdata(wdata0),
`ifdef MEM_BRIDGE_BYTE_EN
    .cpu_be(be0),
`endif
    .mem_rdy(rdy0), .cpu_rdata(rdata0), .mem_err(err0),
    .err_sticky(sticky0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One complete access on the main instance, checked against the model.
  task automatic run_access(input logic is_we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be, input bit drop);
    logic [31:0] off, exp_rdata;
    logic        err;
    int          idx, lat;
    bit          seen;
    off = addr - BASE;
    err = (addr % 4 != 0) || ((off / 4) >= DEPTH);
    idx = err ? 0 : int'(off / 4);

    @(negedge clk);
    cpu_we    = is_we;
    cpu_valid = is_we ? 1'($urandom_range(0, 1)) : 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
`ifdef MEM_BRIDGE_BYTE_EN
    cpu_be    = be;
`endif
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_rdy) seen = 1;
      else if (drop) begin
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
    end
    cpu_valid = 1'b0;
    cpu_we    = 1'b0;
    if (!seen) begin
      check("rdy_timeout", 32'd0, 32'd1);
      return;
    end

    if (err) begin
      sticky_m  = 1'b1;
      exp_rdata = '0;
      hold_m    = '0;
    end else if (is_we) begin
      exp_rdata = hold_m;
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
    end else begin
      exp_rdata = model_mem[idx];
      hold_m    = exp_rdata;
    end

    check("latency", 32'(lat), 32'(1 + WAITS));
    check("mem_err", 32'(mem_err), 32'(err));
    check("rdata", cpu_rdata, exp_rdata);
    check("sticky", 32'(err_sticky), 32'(sticky_m));
    @(negedge clk);
    check("rdy_pulse", 32'(mem_rdy), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d, prior;
    logic [3:0]  be;
    int          r;

    sys_rst = 1'b1;
    cpu_valid = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    valid0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
`ifdef MEM_BRIDGE_BYTE_EN
    cpu_be = 4'hF; be0 = 4'hF;
`endif
    hold_m = '0;
    sticky_m = 1'b0;
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    check("rst_rdy", 32'(mem_rdy), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);

    // Zero-wait instance: writes, then back-to-back reads with the request held.
    w0 = $urandom; w1 = $urandom;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      we0 = 1'b1; addr0 = BASE0 + 32'(4 * k); wdata0 = (k == 0) ? w0 : w1;
      @(negedge clk);
      check("z_wr_rdy", 32'(rdy0), 32'd1);
      we0 = 1'b0;
      @(negedge clk);
      check("z_wr_gap", 32'(rdy0), 32'd0);
    end
    @(negedge clk);
    valid0 = 1'b1; addr0 = BASE0;
    @(negedge clk);
    check("z_rd0_rdy", 32'(rdy0), 32'd1);
    check("z_rd0_data", rdata0, w0);
    addr0 = BASE0 + 32'd4;
    @(negedge clk);
    check("z_gap", 32'(rdy0), 32'd0);
    @(negedge clk);
    check("z_rd1_rdy", 32'(rdy0), 32'd1);
    check("z_rd1_data", rdata0, w1);
    valid0 = 1'b0;
    @(negedge clk);
    check("z_hold", rdata0, w1);
    check("z_sticky_clear", 32'(sticky0), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      valid0 = 1'b1; addr0 = (k == 0) ? BASE0 - 32'd4 : BASE0 + 32'(4 * DEPTH0);
      @(negedge clk);
      check("z_err_rdy", 32'(rdy0), 32'd1);
      check("z_err", 32'(err0), 32'd1);
      check("z_err_rdata", rdata0, 32'd0);
      check("z_err_sticky", 32'(sticky0), 32'd1);
      valid0 = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    valid0 = 1'b1; addr0 = BASE0;
    @(negedge clk);
    check("z_after_err", rdata0, w0);
    valid0 = 1'b0;
    @(negedge clk);

    // Main instance: fill memory, then directed cases.
    for (int i = 0; i < DEPTH; i++) run_access(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 1'b0);
    run_access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    run_access(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    check("deadbeef", hold_m, 32'hDEAD_BEEF);
    run_access(1'b0, 32'h2, 32'h0, 4'hF, 1'b0);
    run_access(1'b1, BASE + 32'(4 * DEPTH), 32'h5555_5555, 4'hF, 1'b0);
    run_access(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF, 1'b0);
    run_access(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
    run_access(1'b1, 32'h30, 32'hC0FF_EE00, 4'hF, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
    run_access(1'b0, 32'h30, 32'h0, 4'hF, 1'b0);

`ifdef MEM_BRIDGE_BYTE_EN
    run_access(1'b1, 32'h40, 32'hAAAA_AAAA, 4'hF, 1'b0);
    run_access(1'b1, 32'h40, 32'h1122_3344, 4'b0101, 1'b0);
    run_access(1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
    check("byte_lanes", hold_m, 32'hAA22_AA44);
    run_access(1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    run_access(1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
`endif

    // Randomized mix of reads, writes, dropped requests and bad addresses.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (r == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      else if (r == 8) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
      else             a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      d = $urandom;
`ifdef MEM_BRIDGE_BYTE_EN
      be = 4'($urandom);
`else
      be = 4'hF;
`endif
      run_access(1'($urandom_range(0, 1)), a, d, be, 1'($urandom_range(0, 1)));
    end

    // Reset during the WAIT of a write to 0x20 must abort it.
    prior = model_mem[8];
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = ~prior;
`ifdef MEM_BRIDGE_BYTE_EN
    cpu_be = 4'hF;
`endif
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    sys_rst = 1'b1; cpu_we = 1'b0;
    @(negedge clk);
    sys_rst = 1'b0;
    check("abort_rdy", 32'(mem_rdy), 32'd0);
    check("abort_err", 32'(mem_err), 32'd0);
    check("abort_sticky", 32'(err_sticky), 32'd0);
    check("abort_busy0", 32'(busy), 32'd0);
    check("abort_rdata", cpu_rdata, 32'd0);
    sticky_m = 1'b0;
    hold_m   = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_rdy", 32'(mem_rdy), 32'd0);
    end
    run_access(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    check("abort_prior", hold_m, prior);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
